// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and width helpers for the BRAM port arbiter.
package bram_arb_pkg;

  localparam int ID_W = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int addr_w(input int depth);
    return clog2(depth);
  endfunction

  function automatic int data_w(input int nb, input int cw);
    return nb * cw;
  endfunction

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_e;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side command/response bundle for the BRAM port arbiter.
interface bram_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int NB_COL  = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*NB_COL-1:0] req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_lock,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_lock,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant starting the search at ptr_i.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] id_o,
  output logic            any_o
);

  logic [N-1:0]  rot;
  logic [ID_W:0] sum;

  always_comb begin
    rot   = N'({req_i, req_i} >> ptr_i);
    sum   = '0;
    id_o  = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && rot[k]) begin
        any_o = 1'b1;
        sum   = {1'b0, ptr_i} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(N))
          sum = sum - (ID_W+1)'(N);
        id_o  = sum[ID_W-1:0];
      end
    end
    gnt_o = any_o ? (N'(1) << id_o) : '0;
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one BRAM port with read-tag return routing.
// Optional grant locking is enabled by defining BRAM_ARB_LOCK_EN.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int NB_COL       = 4,
  parameter  int COL_WIDTH    = 8,
  parameter  int RAM_DEPTH    = 512,
  parameter  int READ_LATENCY = 2,
  localparam int ADDR_W       = addr_w(RAM_DEPTH),
  localparam int DATA_W       = data_w(NB_COL, COL_WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  bram_arb_if.slave         req_if,
  output logic              bram_en,
  output logic [NB_COL-1:0] bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_regce,
  output logic              bram_rst,
  input  logic [DATA_W-1:0] bram_dout
);

  logic [ID_W-1:0]    rr_ptr_q;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_id;
  logic               arb_any;

  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_id;
  logic [NUM_REQ-1:0] gnt_oh;

  logic [NB_COL-1:0]  sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_din;
  logic [NUM_REQ-1:0] rsp_vld;

  tag_t tag_q [READ_LATENCY];
  tag_t tag_d;
  tag_t tag_last;

`ifdef BRAM_ARB_LOCK_EN
  arb_state_e      state_q;
  logic [ID_W-1:0] lk_id_q;
  logic            sel_lock;
`endif

  function automatic logic [ID_W-1:0] nxt(
    input logic [ID_W-1:0] id
  );
    return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req_i (req_if.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .id_o  (arb_id),
    .any_o (arb_any)
  );

  always_comb begin
    gnt_vld = arb_any;
    gnt_id  = arb_id;
    gnt_oh  = arb_gnt;
`ifdef BRAM_ARB_LOCK_EN
    // While locked only the owner may be granted.
    if (state_q == LOCKED) begin
      gnt_vld = 1'b0;
      gnt_id  = lk_id_q;
      gnt_oh  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (lk_id_q == ID_W'(i)) begin
          gnt_vld   = req_if.req_valid[i];
          gnt_oh[i] = req_if.req_valid[i];
        end
      end
    end
`endif
    if (rst) begin
      gnt_vld = 1'b0;
      gnt_oh  = '0;
    end
  end

  assign req_if.req_ready = gnt_oh;

  always_comb begin
    sel_we   = '0;
    sel_addr = '0;
    sel_din  = '0;
`ifdef BRAM_ARB_LOCK_EN
    sel_lock = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        sel_we   = req_if.req_we[i*NB_COL +: NB_COL];
        sel_addr = req_if.req_addr[i*ADDR_W +: ADDR_W];
        sel_din  = req_if.req_wdata[i*DATA_W +: DATA_W];
`ifdef BRAM_ARB_LOCK_EN
        sel_lock = req_if.req_lock[i];
`endif
      end
    end
  end

  assign bram_en   = gnt_vld;
  assign bram_we   = gnt_vld ? sel_we : '0;
  assign bram_addr = sel_addr;
  assign bram_din  = sel_din;
  assign bram_rst  = rst;

  always_comb begin
    tag_d       = '0;
    tag_d.valid = gnt_vld && (sel_we == '0);
    tag_d.id    = gnt_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++)
        tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < READ_LATENCY; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_last = tag_q[READ_LATENCY-1];

  always_comb begin
    rsp_vld = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_vld[i] = !rst && tag_last.valid &&
                   (tag_last.id == ID_W'(i));
  end

  assign req_if.rsp_valid = rsp_vld;
  assign req_if.rsp_data  = bram_dout;

  // The output register only needs to load when a read sits in stage 0.
  generate
    if (READ_LATENCY == 2) begin : g_regce
      assign bram_regce = tag_q[0].valid;
    end else begin : g_noreg
      assign bram_regce = 1'b1;
    end
  endgenerate

`ifdef BRAM_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      lk_id_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      unique case (state_q)
        ARB: begin
          if (gnt_vld) begin
            if (sel_lock) begin
              state_q <= LOCKED;
              lk_id_q <= gnt_id;
            end else begin
              rr_ptr_q <= nxt(gnt_id);
            end
          end
        end
        LOCKED: begin
          if (!gnt_vld || !sel_lock) begin
            state_q  <= ARB;
            rr_ptr_q <= nxt(lk_id_q);
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_if.req_lock;

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr_q <= '0;
    else if (gnt_vld)
      rr_ptr_q <= nxt(gnt_id);
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural byte-enable BRAM port.
// Lock-grant checks apply when BRAM_ARB_LOCK_EN is defined.
module tb_bram_port_arbiter;

  localparam int NR = 4;
  localparam int NB = 4;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          bram_en;
  logic [NB-1:0] bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic          bram_regce;
  logic          bram_rst;
  logic [DW-1:0] bram_dout;

  bram_arb_if #(
    .NUM_REQ (NR),
    .NB_COL  (NB),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) bus ();

  bram_port_arbiter #(
    .NUM_REQ      (NR),
    .NB_COL       (NB),
    .COL_WIDTH    (8),
    .RAM_DEPTH    (512),
    .READ_LATENCY (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_if     (bus),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_regce (bram_regce),
    .bram_rst   (bram_rst),
    .bram_dout  (bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [512];
  logic [DW-1:0] dout_a;
  logic [DW-1:0] out_q;

  always @(posedge clk) begin
    if (bram_en) begin
      dout_a <= mem[bram_addr];
      for (int b = 0; b < NB; b++)
        if (bram_we[b])
          mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
    end
    if (bram_rst)
      out_q <= '0;
    else if (bram_regce)
      out_q <= dout_a;
  end

  assign bram_dout = out_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NR-1:0] v;
    logic [DW-1:0] d;
    int            c;
  } rsp_t;

  rsp_t rsp_q [$];

  always @(negedge clk)
    if (bus.rsp_valid != '0)
      rsp_q.push_back('{bus.rsp_valid, bus.rsp_data, cyc});

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd1(input int r, input logic [NB-1:0] we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int hc);
    bus.req_valid            = '0;
    bus.req_valid[r]         = 1'b1;
    bus.req_we[r*NB +: NB]   = we;
    bus.req_addr[r*AW +: AW] = a;
    bus.req_wdata[r*DW +: DW] = d;
    @(negedge clk);
    chk("gnt", bus.req_ready, 32'(1 << r));
    chk("en", bram_en, 1);
    chk("addr", bram_addr, a);
    chk("we", bram_we, we);
    if (we != '0) chk("din", bram_din, d);
    hc = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = '0;
  endtask

  task automatic exp_rsp(input string tag, input int id,
                         input logic [DW-1:0] d, input int c);
    rsp_t e;
    chk({tag, "_cnt"}, rsp_q.size() > 0, 1);
    if (rsp_q.size() > 0) begin
      e = rsp_q.pop_front();
      chk({tag, "_id"}, e.v, 32'(1 << id));
      chk({tag, "_data"}, e.d, d);
      chk({tag, "_cyc"}, e.c, c);
    end
  endtask

  int h, h1, h2, h0;
  logic [NR-1:0] lk_exp [4];

  initial begin
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_lock  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_en", bram_en, 0);
    chk("rst_rsp", bus.rsp_valid, 0);
    chk("rst_pin", bram_rst, 1);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_valid = '0;

    // full-word write then read back
    cmd1(0, 4'hF, 9'd5, 32'hDEADBEEF, h);
    cmd1(0, 4'h0, 9'd5, 32'h0, h);
    idle(3);
    exp_rsp("rd5", 0, 32'hDEADBEEF, h + 2);
    chk("wr_quiet", rsp_q.size(), 0);

    // preload 10..13, rr_ptr ends at 0
    for (int k = 0; k < NR; k++)
      cmd1(k, 4'hF, AW'(10 + k), 32'h11110000 | k, h);
    idle(3);
    chk("pre_norsp", rsp_q.size(), 0);

    // all requesters valid, reads
    for (int k = 0; k < NR; k++) begin
      bus.req_we[k*NB +: NB]   = '0;
      bus.req_addr[k*AW +: AW] = AW'(10 + k);
    end
    bus.req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_gnt", bus.req_ready, 32'(1 << (i % 4)));
      if (i == 0) h0 = cyc;
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    idle(4);
    for (int i = 0; i < 8; i++)
      exp_rsp("rr_rsp", i % 4, 32'h11110000 | (i % 4), h0 + 2 + i);

    // byte-lane write from R2
    cmd1(2, 4'b0100, 9'd5, 32'h00AA0000, h);
    cmd1(1, 4'h0, 9'd5, 32'h0, h);
    idle(3);
    exp_rsp("be", 1, 32'hDEAABEEF, h + 2);

    // reads in flight dropped by reset
    cmd1(3, 4'h0, 9'd10, 32'h0, h);
    cmd1(1, 4'h0, 9'd11, 32'h0, h);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_rsp", bus.rsp_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    chk("rst_drop", rsp_q.size(), 0);
    bus.req_we    = '1;
    bus.req_valid = '1;
    @(negedge clk);
    chk("rst_ptr", bus.req_ready, 1);
    bus.req_valid = '0;
    @(posedge clk);
    #1;

    // top and bottom addresses
    cmd1(3, 4'hF, 9'd511, 32'hCAFE01FF, h);
    cmd1(3, 4'hF, 9'd0, 32'h0BADF00D, h);
    idle(3);
    chk("edge_norsp", rsp_q.size(), 0);
    cmd1(3, 4'h0, 9'd511, 32'h0, h1);
    cmd1(3, 4'h0, 9'd0, 32'h0, h2);
    idle(3);
    exp_rsp("hi", 3, 32'hCAFE01FF, h1 + 2);
    exp_rsp("lo", 3, 32'h0BADF00D, h2 + 2);

    // R1 lock request with R0/R2 competing, rr_ptr=1 first
    cmd1(0, 4'hF, 9'd20, 32'h1, h);
`ifdef BRAM_ARB_LOCK_EN
    lk_exp[0] = 4'b0010;
    lk_exp[1] = 4'b0010;
    lk_exp[2] = 4'b0010;
    lk_exp[3] = 4'b0100;
`else
    lk_exp[0] = 4'b0010;
    lk_exp[1] = 4'b0100;
    lk_exp[2] = 4'b0001;
    lk_exp[3] = 4'b0100;
`endif
    bus.req_we    = '1;
    bus.req_valid = 4'b0111;
    bus.req_lock  = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lock_gnt", bus.req_ready, lk_exp[i]);
      @(posedge clk);
      #1;
      if (i == 1) bus.req_lock = '0;
      if (i == 2) bus.req_valid = 4'b0101;
    end
    bus.req_valid = '0;
    idle(3);
    chk("lock_norsp", rsp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
